irq_ctrl: RTL and testbench

- Memory-mapped interrupt controller that sits directly downstream of the timer and the other bus devices.
- Collects device irq lines (timer irq on src[0]), latches them as pending, masks them and priority-encodes them.
- Drives one request plus a source id toward CP0, using a req/ack/EOI handshake.
- Uses the same addr[3:2] / we / datai / datao register bus as the other devices on the bridge.

---
 rtl/irq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for the device bridge.
// It latches device irq lines as pending, masks them, picks the lowest-index active
// source and drives a registered request with a source id toward CP0. CP0 takes the
// request with an int_ack pulse, and the handler ends it with an EOI write.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   addr     register select: 0 PEND (W1C), 1 MASK, 2 EDGE, 3 CTRL (bit0 write = EOI)
//   we       single-cycle register write strobe
//   datai    write data
//   datao    read data, combinational from addr
//   src      device irq lines, src[0] = timer
//   int_ack  one-cycle pulse from CP0 when the request is taken
//   int_req  registered interrupt request
//   int_id   id of the requested or in-service source
//
// Build option: define IRQ_CTRL_SYNC_EN to pass src through a 2-flop synchronizer
// before edge detect. This adds 2 cycles of source-to-request latency.
module irq_ctrl #(
  parameter int unsigned NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:2]      addr,
  input  logic            we,
  input  logic [31:0]     datai,
  output logic [31:0]     datao,
  input  logic [NSRC-1:0] src,
  input  logic            int_ack,
  output logic            int_req,
  output logic [2:0]      int_id
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StServ = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, edge_mode_q, src_q, src_s;
  logic [NSRC-1:0] set_v, clr_v, act;
  logic [2:0]      cur_id_q, cur_id_d, best;
  logic            any, ack_take, eoi, int_req_q;
  logic            wr_pend, wr_mask, wr_edge;
  logic            unused_datai;

  assign unused_datai = ^datai[31:NSRC];

`ifdef IRQ_CTRL_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src;
`endif

  assign wr_pend = we && (addr == 2'd0);
  assign wr_mask = we && (addr == 2'd1);
  assign wr_edge = we && (addr == 2'd2);
  assign eoi     = we && (addr == 2'd3) && datai[0];

  assign act = pend_q & mask_q;
  assign any = |act;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    best = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) best = 3'(i);
    end
  end

  // Edge mode sets only on a rising input; level mode sets while high.
  assign set_v = src_s & (~edge_mode_q | ~src_q);

  always_comb begin
    clr_v = '0;
    if (wr_pend) clr_v = datai[NSRC-1:0];
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (ack_take && (cur_id_q == 3'(i))) clr_v[i] = 1'b1;
    end
  end

  // Set beats clear, so a level source that is still high re-pends next cycle.
  assign pend_d = set_v | (pend_q & ~clr_v);

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    ack_take = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          state_d  = StReq;
          cur_id_d = best;
        end
      end
      StReq: begin
        if (!any) begin
          state_d  = StIdle;
          cur_id_d = best;
        end else if (int_ack) begin
          // Freeze the id CP0 just saw and retire that source.
          state_d  = StServ;
          ack_take = 1'b1;
        end else begin
          // Track best so a higher-priority source can pre-empt before ack.
          cur_id_d = best;
        end
      end
      StServ: begin
        if (eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_id_q    <= 3'd0;
      int_req_q   <= 1'b0;
      pend_q      <= '0;
      mask_q      <= '0;
      edge_mode_q <= '0;
      src_q       <= '0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      int_req_q <= (state_d == StReq);
      pend_q    <= pend_d;
      src_q     <= src_s;
      if (wr_mask) mask_q <= datai[NSRC-1:0];
      if (wr_edge) edge_mode_q <= datai[NSRC-1:0];
    end
  end

  assign int_req = int_req_q;
  // cur_id_q is loaded from the next-state id, so it is the registered int_id.
  assign int_id  = cur_id_q;

  always_comb begin
    datao = '0;
    unique case (addr)
      2'd0: datao[NSRC-1:0] = pend_q;
      2'd1: datao[NSRC-1:0] = mask_q;
      2'd2: datao[NSRC-1:0] = edge_mode_q;
      2'd3: datao = {16'b0, state_q, 9'b0, any, 1'b0, cur_id_q};
      default: datao = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios followed by random traffic. The driver pushes the
// expected observation for every cycle into a queue, computed by a behavioural model
// of the controller. A monitor pops and compares on each falling edge.
module tb_irq_ctrl;
  localparam int NSRC = 6;
  localparam int FULL = (1 << NSRC) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:2]      addr = 2'd0;
  logic            we = 1'b0;
  logic [31:0]     datai = '0;
  logic [31:0]     datao;
  logic [NSRC-1:0] src = '0;
  logic            int_ack = 1'b0;
  logic            int_req;
  logic [2:0]      int_id;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .datai(datai), .datao(datao),
    .src(src), .int_ack(int_ack), .int_req(int_req), .int_id(int_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [2:0]  id;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cycle = 0;

  // Model: state 0 idle, 1 requesting, 2 in service.
  int m_pend = 0, m_mask = 0, m_edge = 0, m_srcq = 0, m_s1 = 0, m_s2 = 0;
  int m_state = 0, m_cur = 0, m_req = 0;

  function automatic int lowest(input int v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int model_read(input int a);
    int anyb;
    anyb = ((m_pend & m_mask) != 0) ? 1 : 0;
    case (a)
      0: return m_pend;
      1: return m_mask;
      2: return m_edge;
      default: return (m_state << 14) | (anyb << 4) | m_cur;
    endcase
  endfunction

  task automatic model_step(input bit rst, input int a, input bit w, input int d,
                            input int s, input bit ack);
    int seen, act, best, setv, clr, nstate, ncur;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_edge = 0; m_srcq = 0; m_s1 = 0; m_s2 = 0;
      m_state = 0; m_cur = 0; m_req = 0;
      return;
    end
`ifdef IRQ_CTRL_SYNC_EN
    seen = m_s2;
`else
    seen = s & FULL;
`endif
    act  = m_pend & m_mask;
    best = lowest(act);
    setv = (seen & ~m_srcq & m_edge) | (seen & ~m_edge & FULL);
    clr  = (w && a == 0) ? (d & FULL) : 0;
    nstate = m_state;
    ncur   = m_cur;
    if (m_state == 0) begin
      if (act != 0) begin nstate = 1; ncur = best; end
    end else if (m_state == 1) begin
      if (act == 0) begin nstate = 0; ncur = best; end
      else if (ack) begin nstate = 2; clr = clr | (1 << m_cur); end
      else ncur = best;
    end else begin
      if (w && a == 3 && d[0]) nstate = 0;
    end
    m_pend = (setv | (m_pend & ~clr)) & FULL;
    if (w && a == 1) m_mask = d & FULL;
    if (w && a == 2) m_edge = d & FULL;
    m_srcq  = seen;
    m_s2    = m_s1;
    m_s1    = s & FULL;
    m_state = nstate;
    m_cur   = ncur;
    m_req   = (nstate == 1) ? 1 : 0;
  endtask

  task automatic cyc(input bit rst, input int a, input bit w, input int d,
                     input int s, input bit ack);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rst; addr = a[1:0]; we = w; datai = d; src = s[NSRC-1:0]; int_ack = ack;
    e.req = m_req[0];
    e.id  = m_cur[2:0];
    e.dat = model_read(a);
    exp_q.push_back(e);
    model_step(rst, a, w, d, s, ack);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s cycle=%0d got=%h exp=%h", name, cycle, got, exp);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("int_req", {31'b0, int_req}, {31'b0, e.req});
        chk("int_id", {29'b0, int_id}, {29'b0, e.id});
        chk("datao", datao, e.dat);
      end
    end
  end

  int cs = 0;

  task automatic settle();
    cs = 0;
    cyc(0, 1, 1, 0, cs, 0);
    cyc(0, 0, 1, FULL, cs, 0);
    cyc(0, 3, 1, 1, cs, 0);
    cyc(0, 2, 1, 0, cs, 0);
  endtask

  task automatic ack_when_req(input int a);
    for (int k = 0; k < 8 && m_state != 1; k++) cyc(0, a, 0, 0, cs, 0);
    cyc(0, a, 0, 0, cs, (m_state == 1));
  endtask

  initial begin
    int a, d;
    bit w, r, k;
    // Reset and read back all registers.
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, i, 0, 0, 0, 0);

    // Timer source in level mode: request, ack, re-pend, EOI, re-request.
    cyc(0, 1, 1, 1, 0, 0);
    cyc(0, 2, 1, 0, 0, 0);
    cs = 1;
    cyc(0, 0, 0, 0, cs, 0);
    cyc(0, 0, 0, 0, cs, 0);
    cyc(0, 3, 0, 0, cs, 0);
    ack_when_req(3);
    repeat (3) cyc(0, 0, 0, 0, cs, 0);
    cyc(0, 3, 1, 1, cs, 0);
    repeat (3) cyc(0, 3, 0, 0, cs, 0);
    settle();

    // Pre-emption: src[3] then src[1] before ack.
    cyc(0, 1, 1, 'h3F, cs, 0);
    cs = 'h08;
    repeat (3) cyc(0, 3, 0, 0, cs, 0);
    cs = 'h0A;
    repeat (3) cyc(0, 3, 0, 0, cs, 0);
    ack_when_req(3);
    cs = 'h08;
    cyc(0, 0, 0, 0, cs, 0);
    cyc(0, 3, 0, 0, cs, 0);
    settle();

    // Edge mode on src[2], W1C while the line is still high.
    cyc(0, 1, 1, 'h3F, cs, 0);
    cyc(0, 2, 1, 'h04, cs, 0);
    cs = 'h04;
    cyc(0, 0, 0, 0, cs, 0);
    cyc(0, 0, 0, 0, cs, 0);
    cyc(0, 0, 1, 'h04, cs, 0);
    cyc(0, 0, 0, 0, cs, 0);
    cyc(0, 0, 0, 0, cs, 0);
    cs = 0;
    cyc(0, 0, 0, 0, cs, 0);
    settle();

    // Withdrawal by masking while in REQ for src[4].
    cyc(0, 1, 1, 'h3F, cs, 0);
    cs = 'h10;
    repeat (3) cyc(0, 3, 0, 0, cs, 0);
    cyc(0, 1, 1, 0, cs, 0);
    cyc(0, 3, 0, 0, cs, 0);
    cyc(0, 0, 0, 0, cs, 0);
    settle();

    // Reset while in service.
    cyc(0, 1, 1, 1, cs, 0);
    cs = 1;
    ack_when_req(3);
    cyc(0, 3, 0, 0, cs, 0);
    cyc(1, 3, 0, 0, cs, 0);
    cs = 0;
    for (int i = 0; i < 4; i++) cyc(0, i, 0, 0, cs, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) cs = cs ^ (1 << $urandom_range(0, NSRC - 1));
      r = ($urandom_range(0, 249) == 0);
      a = $urandom_range(0, 3);
      w = ($urandom_range(0, 4) == 0);
      d = $urandom;
      if (a == 1 && $urandom_range(0, 1) == 0) d = d | FULL;
      k = (m_state == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      cyc(r, a, w, d, cs, k);
    end

    cyc(0, 0, 0, 0, cs, 0);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
